mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles waiting for m_ready before abort.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_req  in  1  instruction-fetch read request, held until i_ready.
REQ-007 SHALL have port i_addr  in  AW  fetch address.
REQ-008 SHALL have port i_ready  out  1  one-cycle pulse: fetch access complete.
REQ-009 SHALL have port i_rdata  out  DW  fetch read data, valid while i_ready=1.
REQ-010 SHALL have port d_req  in  1  load/store request, held until d_ready.
REQ-011 SHALL have port d_we  in  1  1=store, 0=load.
REQ-012 SHALL have port d_addr  in  AW  load/store address.
REQ-013 SHALL have port d_wdata  in  DW  store data.
REQ-014 SHALL have port d_ready  out  1  one-cycle pulse: load/store complete.
REQ-015 SHALL have port d_rdata  out  DW  load data, valid while d_ready=1.
REQ-016 SHALL have port m_req  out  1  memory request, held until m_ready or abort.
REQ-017 SHALL have port m_we  out  1  memory write enable, valid with m_req.
REQ-018 SHALL have port m_addr  out  AW  memory address, valid with m_req.
REQ-019 SHALL have port m_wdata  out  DW  memory write data, valid with m_req.
REQ-020 SHALL have port m_rdata  in  DW  memory read data, sampled when m_ready=1.
REQ-021 SHALL have port m_ready  in  1  memory completion pulse.
REQ-022 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-023 SHALL implement FSM IDLE -> GRANT -> WAIT -> DONE -> IDLE; one access in flight at a time.
REQ-024 IDLE: requests sampled; if any pending, latch winner, its addr/we/wdata, go GRANT; else stay.
REQ-025 Arbitration SHALL be round-robin: on simultaneous i_req and d_req, grant the port not served last; last_grant resets to D, so I wins the first tie.
REQ-026 Single request SHALL be granted regardless of last_grant.
REQ-027 GRANT: assert m_req with latched fields, clear timeout counter, go WAIT; minimum latency i_req/d_req to m_req = 2 cycles.
REQ-028 WAIT: on m_ready=1, drop m_req, capture m_rdata, go DONE; i_ready/d_ready pulses one cycle later (in DONE).
REQ-029 WAIT: counter increments each cycle without m_ready; at count==TIMEOUT, drop m_req, set err, return rdata all-zero, go DONE.
REQ-030 DONE: pulse only the granted port's ready for exactly one cycle with captured data, update last_grant, go IDLE; no new grant in DONE (requester drops req on the edge sampling ready).
REQ-031 Requests arriving during GRANT/WAIT/DONE SHALL wait; none are dropped while held.
REQ-032 m_we SHALL be 0 for fetch grants; m_wdata don't-care when m_we=0.
REQ-033 Latched request fields SHALL NOT change while a grant is active even if requester inputs change.
REQ-034 m_ready outside WAIT SHALL be ignored.
REQ-035 Store: d_rdata all-zero on d_ready.

Reset
REQ-036 On rst=0 at clk edge: state IDLE, m_req/m_we/i_ready/d_ready/err=0, m_addr/m_wdata/i_rdata/d_rdata=0, counter=0, last_grant=D; reset mid-access abandons it with no ready pulse.
REQ-037 err SHALL clear only by reset.

Structure
REQ-038 FSM state encoding and grant-ID constants (GNT_I, GNT_D) SHALL live in shared package cpu_pkg.
REQ-039 Round-robin choice SHALL be sub-module rr_arb2 (2-way, inputs req pair + last_grant, output one-hot grant).

Verification
REQ-040 Fetch only: i_req=1, i_addr=8'h10, memory m_ready 2 cycles after m_req, m_rdata=8'hA5 -> m_addr=8'h10, m_we=0, i_ready pulse with i_rdata=8'hA5.
REQ-041 Tie after reset: i_req and d_req rise same cycle -> I served first, then D; back-to-back tie -> order I,D,I,D.
REQ-042 Store: d_req=1, d_we=1, d_addr=8'h20, d_wdata=8'h3C -> m_we=1, m_addr=8'h20, m_wdata=8'h3C, d_ready pulse, d_rdata=0.
REQ-043 Timeout: m_ready never asserted -> m_req drops after 15 WAIT cycles, err=1, i_ready pulse with i_rdata=0.
REQ-044 Reset mid-WAIT: rst=0 one cycle -> all outputs 0, no ready pulse, next request served normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared arbiter types: FSM state encoding and grant-ID constants.
// Pure declarations, no logic.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (fetch/load-store) and memory handshake bundle for mem_arbiter.
// master: arbiter view; slave: requesters plus memory model view.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    logic          err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_ready, i_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata, err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_ready, i_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata, err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: one-hot grant, combinational (0 cycles).
// On a tie the port not served last wins; a lone request always wins.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic [1:0] req,         // [0] = fetch port, [1] = data port
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == GNT_I) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one memory port, one access in flight.
// Request to m_req is 2 cycles; requesters hold req until their one-cycle ready pulse.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    logic [1:0]    gnt_oh;
    logic [CW-1:0] cnt_inc;
    logic          done_now;
    logic [DW-1:0] rdata_cap;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.d_req, bus.i_req}),
        .last_grant (last_q),
        .gnt        (gnt_oh)
    );

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        done_now  = 1'b0;
        rdata_cap = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_oh != 2'b00) begin
                    gnt_d   = gnt_oh[1] ? GNT_D : GNT_I;
                    addr_d  = gnt_oh[1] ? bus.d_addr : bus.i_addr;
                    we_d    = gnt_oh[1] & bus.d_we;
                    wdata_d = gnt_oh[1] ? bus.d_wdata : '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                m_req_d = 1'b1;
                m_we_d  = we_q;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (bus.m_ready) begin
                    done_now  = 1'b1;
                    rdata_cap = we_q ? '0 : bus.m_rdata;
                end else if (cnt_inc == TO_LAST) begin
                    done_now = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (done_now) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = ST_DONE;
                    if (gnt_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = rdata_cap;
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = rdata_cap;
                    end
                end
            end
            ST_DONE: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_I;
            last_q    <= GNT_D;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ready = d_ready_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks push expected read data,
// a negedge monitor pops on each ready pulse; a memory model checks each access.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(8), .DW(8)) bus ();

    mem_arbiter #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] mem_arr [256];
    logic [7:0] exp_i [$];
    logic [7:0] exp_d [$];
    bit         grant_log [$];

    bit         pend_i_vld = 0, pend_d_vld = 0, pend_d_we = 0;
    logic [7:0] pend_i_addr = 0, pend_d_addr = 0, pend_d_wdata = 0;

    int  dly_min = 0, dly_max = 4;
    bit  mem_never = 0, spurious_en = 0;
    bit  acc_we;
    logic [7:0] acc_addr, acc_wdata;
    int  acc_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the next expected response of that port.
    bit prev_i = 0, prev_d = 0;
    always @(negedge clk) begin
        if (bus.i_ready) begin
            checks++;
            if (exp_i.size() == 0) begin
                fails++;
                $display("FAIL i_ready_unexpected: got pulse with data %0h expected none", bus.i_rdata);
            end else begin
                logic [7:0] e;
                e = exp_i.pop_front();
                if (bus.i_rdata !== e) begin
                    fails++;
                    $display("FAIL i_rdata: got %0h expected %0h", bus.i_rdata, e);
                end
            end
            grant_log.push_back(1'b0);
        end
        if (bus.d_ready) begin
            checks++;
            if (exp_d.size() == 0) begin
                fails++;
                $display("FAIL d_ready_unexpected: got pulse with data %0h expected none", bus.d_rdata);
            end else begin
                logic [7:0] e;
                e = exp_d.pop_front();
                if (bus.d_rdata !== e) begin
                    fails++;
                    $display("FAIL d_rdata: got %0h expected %0h", bus.d_rdata, e);
                end
            end
            grant_log.push_back(1'b1);
        end
        if ((bus.i_ready && (prev_i || bus.d_ready)) || (bus.d_ready && prev_d)) begin
            fails++;
            $display("FAIL ready_pulse: got i=%0b d=%0b prev_i=%0b prev_d=%0b expected single one-cycle pulse",
                     bus.i_ready, bus.d_ready, prev_i, prev_d);
        end
        prev_i = bus.i_ready;
        prev_d = bus.d_ready;
    end

    // Memory model: checks each new access against the pending request, then responds.
    initial begin
        int cd;
        bit active;
        bit ok;
        active = 0;
        cd = 0;
        bus.m_ready = 1'b0;
        bus.m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!bus.m_req) begin
                active = 0;
                bus.m_ready = 1'b0;
                if (spurious_en && $urandom_range(7) == 0) begin
                    bus.m_ready = 1'b1;
                    bus.m_rdata = 8'($urandom);
                end
            end else begin
                if (!active) begin
                    active    = 1;
                    acc_len   = 0;
                    acc_we    = bus.m_we;
                    acc_addr  = bus.m_addr;
                    acc_wdata = bus.m_wdata;
                    cd = mem_never ? 1000 : $urandom_range(dly_max, dly_min);
                    if (acc_we)
                        ok = pend_d_vld && pend_d_we && pend_d_addr == acc_addr && pend_d_wdata == acc_wdata;
                    else
                        ok = (pend_i_vld && pend_i_addr == acc_addr) ||
                             (pend_d_vld && !pend_d_we && pend_d_addr == acc_addr);
                    checks++;
                    if (!ok) begin
                        fails++;
                        $display("FAIL mem_access: got we=%0b addr=%0h wdata=%0h expected a pending request (i %0b/%0h, d %0b/%0b/%0h/%0h)",
                                 acc_we, acc_addr, acc_wdata, pend_i_vld, pend_i_addr,
                                 pend_d_vld, pend_d_we, pend_d_addr, pend_d_wdata);
                    end
                end
                acc_len++;
                if (cd == 0) begin
                    bus.m_ready = 1'b1;
                    if (acc_we) begin
                        mem_arr[acc_addr] = acc_wdata;
                        bus.m_rdata = 8'($urandom);
                    end else begin
                        bus.m_rdata = mem_arr[acc_addr];
                    end
                end else begin
                    bus.m_ready = 1'b0;
                    cd--;
                end
            end
        end
    end

    task automatic wait_ready(input bit port_d, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port_d ? bus.d_ready : bus.i_ready) && n < 64);
        if (!(port_d ? bus.d_ready : bus.i_ready)) begin
            checks++;
            fails++;
            $display("FAIL %s: got no ready within 64 cycles expected a ready pulse", name);
        end
    endtask

    task automatic do_fetch(input logic [7:0] a, input bit expect_abort);
        exp_i.push_back(expect_abort ? 8'h00 : ref_mem[a]);
        pend_i_vld  = 1;
        pend_i_addr = a;
        bus.i_addr  = a;
        bus.i_req   = 1'b1;
        wait_ready(1'b0, "fetch_wait");
        bus.i_req  = 1'b0;
        pend_i_vld = 0;
        bus.i_addr = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic do_access(input bit we, input logic [7:0] a, input logic [7:0] w);
        exp_d.push_back(we ? 8'h00 : ref_mem[a]);
        if (we) ref_mem[a] = w;
        pend_d_vld   = 1;
        pend_d_we    = we;
        pend_d_addr  = a;
        pend_d_wdata = w;
        bus.d_we     = we;
        bus.d_addr   = a;
        bus.d_wdata  = w;
        bus.d_req    = 1'b1;
        wait_ready(1'b1, "data_wait");
        bus.d_req   = 1'b0;
        pend_d_vld  = 0;
        bus.d_addr  = 8'($urandom);
        bus.d_wdata = 8'($urandom);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test expected finish before 400us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i) ^ 8'h5A;
            mem_arr[i] = 8'(i) ^ 8'h5A;
        end
        ref_mem[8'h10] = 8'hA5;
        mem_arr[8'h10] = 8'hA5;
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_req",   bus.m_req, 0);
        chk("rst_m_we",    bus.m_we, 0);
        chk("rst_m_addr",  bus.m_addr, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_i_ready", bus.i_ready, 0);
        chk("rst_d_ready", bus.d_ready, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_err",     bus.err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Two simultaneous ties straight after reset: fetch first each round.
        grant_log.delete();
        for (int r = 0; r < 2; r++) begin
            fork
                do_fetch(8'(8'h01 + r), 1'b0);
                do_access(1'b0, 8'(8'h81 + r), 8'h00);
            join
        end
        chk("tie_count", grant_log.size(), 4);
        if (grant_log.size() == 4)
            chk("tie_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);

        // Fetch re-requests while the data port waits: data must get the next turn.
        grant_log.delete();
        fork
            begin
                do_fetch(8'h05, 1'b0);
                do_fetch(8'h06, 1'b0);
            end
            do_access(1'b0, 8'h85, 8'h00);
        join
        chk("rr_count", grant_log.size(), 3);
        if (grant_log.size() == 3)
            chk("rr_order", {grant_log[0], grant_log[1], grant_log[2]}, 3'b010);

        // Directed fetch: latency, address hold against input changes, data.
        dly_min = 2; dly_max = 2;
        exp_i.push_back(8'hA5);
        pend_i_vld = 1; pend_i_addr = 8'h10;
        bus.i_addr = 8'h10; bus.i_req = 1'b1;
        @(negedge clk);
        chk("fetch_m_req_c1", bus.m_req, 0);
        @(negedge clk);
        chk("fetch_m_req_c2", bus.m_req, 1);
        chk("fetch_m_addr",   bus.m_addr, 8'h10);
        chk("fetch_m_we",     bus.m_we, 0);
        bus.i_addr = 8'hFF;
        @(negedge clk);
        chk("fetch_addr_hold", bus.m_addr, 8'h10);
        wait_ready(1'b0, "fetch_wait");
        bus.i_req = 1'b0; pend_i_vld = 0;
        @(negedge clk);

        // Directed store then read-back.
        do_access(1'b1, 8'h20, 8'h3C);
        chk("store_m_we",    acc_we, 1);
        chk("store_m_addr",  acc_addr, 8'h20);
        chk("store_m_wdata", acc_wdata, 8'h3C);
        do_access(1'b0, 8'h20, 8'h00);

        // Random concurrent traffic with spurious m_ready outside accesses.
        dly_min = 0; dly_max = 4; spurious_en = 1;
        fork
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(3)) @(negedge clk);
                do_fetch(8'($urandom_range(127)), 1'b0);
            end
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(3)) @(negedge clk);
                do_access(1'($urandom_range(1)), 8'(8'h80 + $urandom_range(127)), 8'($urandom));
            end
        join
        spurious_en = 0;
        @(negedge clk);
        chk("rand_err", bus.err, 0);

        // Timeout: memory never answers.
        mem_never = 1;
        do_fetch(8'h30, 1'b1);
        chk("to_m_req_len", acc_len, 15);
        chk("to_err",       bus.err, 1);
        mem_never = 0;
        do_fetch(8'h31, 1'b0);
        chk("err_sticky", bus.err, 1);

        // Reset during WAIT abandons the access without a ready pulse.
        mem_never = 1;
        pend_i_vld = 1; pend_i_addr = 8'h40;
        bus.i_addr = 8'h40; bus.i_req = 1'b1;
        n = 0;
        while (!bus.m_req && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_m_req_up", bus.m_req, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.i_req = 1'b0; pend_i_vld = 0;
        @(negedge clk);
        rst = 1'b1;
        chk("rstmid_m_req",   bus.m_req, 0);
        chk("rstmid_i_ready", bus.i_ready, 0);
        chk("rstmid_i_rdata", bus.i_rdata, 0);
        chk("rstmid_m_addr",  bus.m_addr, 0);
        chk("rstmid_err",     bus.err, 0);
        repeat (5) @(negedge clk);
        mem_never = 0;
        do_fetch(8'h44, 1'b0);

        repeat (3) @(negedge clk);
        chk("exp_i_drained", exp_i.size(), 0);
        chk("exp_d_drained", exp_d.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
